// File: rtl/comm_assist_pkg.sv
// Shared definitions for the communication assist: flit ctrl encodings and
// the reply-port arbiter state type.
package comm_assist_pkg;

  localparam logic [1:0] CTRL_HEAD = 2'b01;
  localparam logic [1:0] CTRL_BODY = 2'b10;
  localparam logic [1:0] CTRL_TAIL = 2'b11;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rr_pick_onehot.sv
// Combinational N-way cyclic priority picker: first set request at or after
// rr_ptr, wrapping at N-1. Returns the one-hot grant and its index.
module rr_pick_onehot #(
  parameter int N     = 3,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             req_any
);

  // Scan from the farthest offset down so the candidate closest to rr_ptr
  // is the last one written and therefore wins.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned
    // (which would infer a latch).
    grant     = '0;
    grant_idx = '0;
    req_any   = |req;
    for (int k = N - 1; k >= 0; k--) begin
      int idx;
      idx = (int'(rr_ptr) + k) % N;
      if (req[idx]) begin
        grant     = '0;
        grant[idx] = 1'b1;
        grant_idx = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/arbiter_for_out_rep.sv
// Credit-based, packet-locking round-robin arbiter for the shared OUT_rep
// reply port. Grants one source per packet and holds it until the tail flit.
module arbiter_for_out_rep
  import comm_assist_pkg::*;
#(
  parameter int N       = 3,
  parameter int CREDITS = 4,
  parameter int CNT_W   = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     v_req,
  input  logic [2*N-1:0]   req_ctrl,
  input  logic             credit_return,
  output logic [N-1:0]     ack_req,
  output logic [N-1:0]     select,
  output logic             v_OUT_rep,
  output logic [CNT_W-1:0] credits,
  output logic             busy,
  output logic             credit_err
);

  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [CNT_W-1:0] credits_q;
  logic             credit_err_q;

  logic [N-1:0]     pick_grant;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_any;
  logic [N-1:0]     ack_int;
  logic             issue;

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
    return (idx == IDX_W'(N - 1)) ? '0 : idx + 1'b1;
  endfunction

  function automatic logic is_tail(input logic [2*N-1:0] ctrl,
                                   input logic [IDX_W-1:0] idx);
    return ctrl[2*int'(idx) +: 2] == CTRL_TAIL;
  endfunction

  rr_pick_onehot #(.N(N), .IDX_W(IDX_W)) u_pick (
    .req       (v_req),
    .rr_ptr    (rr_ptr_q),
    .grant     (pick_grant),
    .grant_idx (pick_idx),
    .req_any   (pick_any)
  );

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    ack_int  = '0;
    if (credits_q != '0) begin
      unique case (state_q)
        ARB_IDLE: begin
          if (pick_any) begin
            ack_int = pick_grant;
            if (is_tail(req_ctrl, pick_idx)) begin
              rr_ptr_d = next_idx(pick_idx);
            end else begin
              owner_d = pick_idx;
              state_d = ARB_LOCKED;
            end
          end
        end
        ARB_LOCKED: begin
          if (v_req[owner_q]) begin
            ack_int = N'(1) << owner_q;
            if (is_tail(req_ctrl, owner_q)) begin
              rr_ptr_d = next_idx(owner_q);
              state_d  = ARB_IDLE;
            end
          end
        end
        default: state_d = ARB_IDLE;
      endcase
    end
  end

  // Acks are suppressed during reset so a half-sent packet cannot advance.
  assign ack_req    = rst ? '0 : ack_int;
  assign select     = ack_req;
  assign v_OUT_rep  = |ack_req;
  assign issue      = v_OUT_rep;
  assign busy       = !rst && (state_q == ARB_LOCKED);
  assign credits    = credits_q;
  assign credit_err = credit_err_q;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ARB_IDLE;
      rr_ptr_q     <= '0;
      owner_q      <= '0;
      credits_q    <= CNT_W'(CREDITS);
      credit_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      if (issue && !credit_return) begin
        credits_q <= credits_q - 1'b1;
      end else if (!issue && credit_return) begin
        if (credits_q == CNT_W'(CREDITS)) begin
          credit_err_q <= 1'b1;
        end else begin
          credits_q <= credits_q + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_arbiter_for_out_rep.sv
// Self-checking bench for arbiter_for_out_rep: directed scenarios plus random
// traffic, compared each cycle against a packet-level reference model.
module tb_arbiter_for_out_rep;

  localparam int N       = 3;
  localparam int CREDITS = 4;
  localparam int CNT_W   = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [N-1:0]     v_req = '0;
  logic [2*N-1:0]   req_ctrl = '0;
  logic             credit_return = 1'b0;
  logic [N-1:0]     ack_req;
  logic [N-1:0]     select;
  logic             v_OUT_rep;
  logic [CNT_W-1:0] credits;
  logic             busy;
  logic             credit_err;

  arbiter_for_out_rep #(.N(N), .CREDITS(CREDITS), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .v_req         (v_req),
    .req_ctrl      (req_ctrl),
    .credit_return (credit_return),
    .ack_req       (ack_req),
    .select        (select),
    .v_OUT_rep     (v_OUT_rep),
    .credits       (credits),
    .busy          (busy),
    .credit_err    (credit_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: owner = -1 means no packet in progress.
  int m_owner   = -1;
  int m_rr      = 0;
  int m_credits = CREDITS;
  bit m_err     = 1'b0;
  int last_win  = -1;

  task automatic chk(input string tag, input string what,
                     input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s %s: observed %0h expected %0h", tag, what, got, exp);
    end
  endtask

  function automatic int ctrl_of(input int src);
    logic [2*N-1:0] sh;
    sh = req_ctrl >> (2 * src);
    return int'(sh[1:0]);
  endfunction

  function automatic int model_winner();
    int w;
    w = -1;
    if (!rst && m_credits != 0) begin
      if (m_owner < 0) begin
        for (int k = 0; k < N; k++) begin
          int i;
          i = (m_rr + k) % N;
          if (w < 0 && v_req[i]) w = i;
        end
      end else if (v_req[m_owner]) begin
        w = m_owner;
      end
    end
    return w;
  endfunction

  // Inputs are set before the call; outputs are sampled on the falling edge,
  // then the model advances on the rising edge.
  task automatic cycle(input string tag);
    int w;
    logic [31:0] exp_ack;
    @(negedge clk);
    w = model_winner();
    exp_ack = (w >= 0) ? (32'd1 << w) : 32'd0;
    chk(tag, "ack_req", 32'(ack_req), exp_ack);
    chk(tag, "select", 32'(select), exp_ack);
    chk(tag, "v_OUT_rep", 32'(v_OUT_rep), 32'(w >= 0));
    chk(tag, "busy", 32'(busy), 32'(!rst && m_owner >= 0));
    if (!rst) begin
      chk(tag, "credits", 32'(credits), 32'(m_credits));
      chk(tag, "credit_err", 32'(credit_err), 32'(m_err));
    end
    last_win = w;
    @(posedge clk);
    if (rst) begin
      m_owner = -1; m_rr = 0; m_credits = CREDITS; m_err = 1'b0;
    end else begin
      if (w >= 0) begin
        if (ctrl_of(w) == 3) begin
          m_owner = -1;
          m_rr = (w + 1) % N;
        end else begin
          m_owner = w;
        end
      end
      m_credits = m_credits + int'(credit_return) - int'(w >= 0);
      if (m_credits > CREDITS) begin
        m_credits = CREDITS;
        m_err = 1'b1;
      end
    end
    #1;
  endtask

  task automatic set_ctrl(input int src, input logic [1:0] c);
    req_ctrl[2*src +: 2] = c;
  endtask

  initial begin
    logic [1:0] pkt6 [6];
    int flit;
    pkt6 = '{2'b01, 2'b10, 2'b10, 2'b00, 2'b10, 2'b11};

    // Reset, then a single-flit packet from source 0.
    rst = 1'b1; cycle("reset");
    rst = 1'b0;
    v_req = 3'b001; set_ctrl(0, 2'b11); cycle("single");
    v_req = 3'b000; cycle("single_after");

    // Three-way contention of single-flit packets with steady returns.
    v_req = 3'b111; req_ctrl = 6'b111111; credit_return = 1'b1;
    for (int i = 0; i < 4; i++) cycle("contend");

    // Packet lock on source 1 while source 0 keeps requesting.
    v_req = 3'b011; set_ctrl(0, 2'b11); set_ctrl(1, 2'b01); cycle("lock_head");
    credit_return = 1'b0; v_req = 3'b001; cycle("lock_stall0"); cycle("lock_stall1");
    credit_return = 1'b1; v_req = 3'b011; set_ctrl(1, 2'b10); cycle("lock_body0");
    cycle("lock_body1");
    set_ctrl(1, 2'b11); cycle("lock_tail");
    v_req = 3'b001; cycle("after_tail");
    v_req = 3'b000; credit_return = 1'b0; cycle("lock_idle");

    // Credit exhaustion on a 6-flit packet with two delayed returns.
    rst = 1'b1; cycle("rst_credit");
    rst = 1'b0; flit = 0; v_req = 3'b001;
    for (int c = 0; c < 20 && flit < 6; c++) begin
      set_ctrl(0, pkt6[flit]);
      credit_return = (c == 6 || c == 8);
      cycle("exhaust");
      if (last_win == 0) flit++;
    end
    chk("exhaust", "flits_sent", 32'(flit), 32'd6);
    v_req = 3'b000; credit_return = 1'b1; cycle("refill");
    v_req = 3'b001; set_ctrl(0, 2'b11); cycle("simul0"); cycle("simul1");
    v_req = 3'b000; credit_return = 1'b0; cycle("simul_idle");

    // Overflow sets the sticky error, cleared only by reset.
    rst = 1'b1; cycle("rst_ovf");
    rst = 1'b0; credit_return = 1'b1; cycle("overflow");
    credit_return = 1'b0;
    for (int i = 0; i < 3; i++) cycle("sticky");
    rst = 1'b1; cycle("rst_clear");
    rst = 1'b0; cycle("cleared");

    // Reset in the middle of a source 2 packet.
    v_req = 3'b100; set_ctrl(2, 2'b01); cycle("mid_head");
    set_ctrl(2, 2'b10); cycle("mid_body");
    rst = 1'b1; cycle("mid_rst");
    rst = 1'b0; v_req = 3'b000; cycle("post_rst");
    v_req = 3'b101; set_ctrl(0, 2'b11); cycle("post_rst_grant");

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 49) == 0);
      v_req = N'($urandom);
      req_ctrl = (2*N)'($urandom);
      credit_return = ($urandom_range(0, 1) == 1);
      cycle("random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/arbiter_for_out_rep.md
Name: arbiter_for_OUT_rep

Overview:
- Credit-based, packet-locking round-robin arbiter for the shared OUT_rep reply port of the communication assist.
- N upload sources (default: dc reply, mem reply, ic forward) each present flits tagged with a 2-bit ctrl field.
- The block picks one source per packet, holds the grant until the tail flit, and throttles on downstream credits, not a ready level.
- It drives the source acks, the datapath mux one-hot select, and the OUT_rep write strobe.

Parameters:
- N, 3: number of requesters.
- CREDITS, 4: downstream OUT_rep buffer depth; reset credit count.
- CNT_W, 3: credit counter width; must satisfy 2^CNT_W > CREDITS.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- v_req  in  N  per-source flit valid.
- req_ctrl  in  2N  per-source ctrl, source i at [2i+1:2i]: 01 head, 10 body, 11 tail.
- credit_return  in  1  downstream freed one slot this cycle.
- ack_req  out  N  one-hot; flit of source i is consumed this cycle.
- select  out  N  one-hot datapath mux select; equals ack_req.
- v_OUT_rep  out  1  write strobe into OUT_rep; equals |ack_req.
- credits  out  CNT_W  current credit count.
- busy  out  1  high while in LOCKED state.
- credit_err  out  1  sticky; set on credit overflow.

Behaviour:
- Reset values: state IDLE, rr_ptr=0, credits=CREDITS, credit_err=0.
- Reset outputs: ack_req, select, v_OUT_rep and busy are all 0.
- ack_req, select and v_OUT_rep are combinational from state, rr_ptr, credits and inputs: zero latency, the flit moves in the cycle the ack is high.
- Issue requires credits != 0. At credits==0 there are no acks in either state; the state holds.
- IDLE state:
  - If any v_req is set, grant the first set bit scanning cyclically from rr_ptr upward (rr_ptr, rr_ptr+1, ..., wrapping at N-1).
  - If the granted ctrl==11 (single-flit packet), stay in IDLE and set rr_ptr=winner+1 mod N.
  - Otherwise latch owner=winner and go to LOCKED.
- LOCKED state:
  - Only the owner may be acked. If v_req[owner]=0, stall with no ack and stay LOCKED; other requesters are ignored.
  - On ack with ctrl==11, go to IDLE and set rr_ptr=owner+1 mod N. The next packet can be granted the following cycle.
  - Body and head ctrl values while locked are forwarded unchanged.
- Credit counter:
  - Decrement on issue, increment on credit_return.
  - Both in the same cycle: count unchanged.
  - credit_return while credits==CREDITS and no issue: count saturates at CREDITS and credit_err is set. credit_err clears only on rst.
- Ctrl value 00 from a valid source is treated as body. The arbiter does not check packet framing.
- rst mid-packet drops the lock. The source must restart its packet; the arbiter guarantees no ack in the reset cycle.
- Priority is fair per packet, not per flit: a source can win at most once every N packets while others are waiting.

Decomposition:
- Shared package (comm_assist_pkg):
  - ctrl encodings CTRL_HEAD=2'b01, CTRL_BODY=2'b10, CTRL_TAIL=2'b11.
  - state encodings ARB_IDLE, ARB_LOCKED.
- One sub-module, rr_pick_onehot: combinational N-way cyclic priority picker.
  - Inputs: request vector, rr_ptr.
  - Outputs: one-hot grant and its index.
  - Reusable by the IN side.
- Credit counter and FSM stay in the top module.

Test Plan:
- Reset then single request: v_req=001, ctrl0=11, credits=4 -> ack_req=001 for one cycle, v_OUT_rep=1, credits=3, rr_ptr=1, state stays IDLE.
- Three-way contention, each source sending a 1-flit packet, rr_ptr=0, credits returned every cycle -> grants in order 001, 010, 100, 001, one per cycle.
- Packet lock: source 1 sends head, body, body, tail while source 0 holds v_req=1. Source 1 drops valid for 2 cycles after the head -> ack only on source 1's valid cycles, busy=1 throughout, source 0 granted the cycle after the tail.
- Credit exhaustion: 6-flit packet, CREDITS=4, no returns -> 4 acks, then stall with credits=0. Pulse credit_return twice -> 2 more acks, credits=0. Simultaneous issue and return keeps the count constant.
- Overflow: credit_return at credits=4 with no traffic -> credits stays 4, credit_err=1 and remains set until rst.
- Reset mid-packet: rst asserted after the body flit of a source 2 packet -> next cycle state IDLE, credits=4, rr_ptr=0, busy=0, no ack during the rst cycle.
